// File: rtl/amm_read_issuer_pkg.sv
// Shared types and helpers for the AMM read issuer and the compare stage.
// Both stages call lfsr8_step, so their pattern sequences stay in lockstep.
package amm_read_issuer_pkg;

  localparam int unsigned AMM_ADDR_W  = 16;
  localparam int unsigned AMM_BURST_W = 7;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef struct packed {
    logic [AMM_ADDR_W-1:0]  start_addr;
    logic [AMM_BURST_W-2:0] words_count;
    logic [7:0]             data_ptrn;
    data_mode_t             data_mode;
  } cmp_desc_t;

  function automatic logic [7:0] lfsr8_step(input logic [7:0] p);
    return {p[6:0], p[6] ^ p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/amm_read_issuer_credit_cnt.sv
// Outstanding-credit counter: add N on issue, subtract 1 on consume, and
// report whether another N would still fit under MAX.
module credit_cnt #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] inc_n_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] need_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             ok_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_d + inc_n_i;
    // A consume while empty is spurious and is dropped.
    if (dec_i && (cnt_q != '0)) cnt_d = cnt_d - WIDTH'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sum   = {1'b0, cnt_q} + {1'b0, need_i};
  assign ok_o  = (sum <= (WIDTH+1)'(MAX));
  assign cnt_o = cnt_q;

endmodule

// File: rtl/amm_read_issuer.sv
// Issues a programmed number of Avalon-MM read bursts over a wrapping address
// window and pushes one compare descriptor per accepted burst, credit-limited.
module amm_read_issuer
  import amm_read_issuer_pkg::*;
#(
  parameter int unsigned DESC_CREDITS = 4,
  parameter int unsigned WORD_CREDITS = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         test_start_i,
  input  logic [AMM_ADDR_W-1:0]        start_addr_i,
  input  logic [AMM_ADDR_W-1:0]        end_addr_i,
  input  logic [AMM_BURST_W-1:0]       burst_words_i,
  input  logic [31:0]                  trans_num_i,
  input  logic [7:0]                   data_ptrn_i,
  input  logic                         data_mode_i,
  output logic [AMM_ADDR_W-1:0]        address_o,
  output logic                         read_o,
  output logic [AMM_BURST_W-1:0]       burstcount_o,
  input  logic                         waitrequest_i,
  output logic                         cmp_en_o,
  output logic [$bits(cmp_desc_t)-1:0] cmp_desc_o,
  input  logic                         cmp_desc_rd_i,
  input  logic                         cmp_word_rd_i,
  input  logic                         cmp_error_i,
  output logic                         busy_o,
  output logic [31:0]                  trans_done_o
);

  localparam int unsigned DESC_W = $clog2(DESC_CREDITS + 1);
  localparam int unsigned WORD_W = $clog2(WORD_CREDITS + 1);

  typedef enum logic [2:0] {
    IDLE_S, LOAD_S, CREDIT_S, ISSUE_S, ADV_S, NEXT_S, DRAIN_S, STOP_S
  } state_t;

  state_t                 state_q, state_d;
  logic [AMM_ADDR_W-1:0]  start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic [AMM_BURST_W-1:0] burst_q, burst_d, adv_q, adv_d;
  logic [31:0]            remaining_q, remaining_d, trans_done_q, trans_done_d;
  logic [7:0]             ptrn_q, ptrn_d;
  data_mode_t             mode_q, mode_d;
  logic                   stop_pend_q, stop_pend_d, busy_q;

  logic                   accept;
  logic                   desc_ok, word_ok;
  logic [DESC_W-1:0]      desc_out;
  logic [WORD_W-1:0]      word_out;
  logic [AMM_ADDR_W:0]    next_addr, next_last;
  logic                   wrap;
  logic [AMM_BURST_W-1:0] words_m1;
  cmp_desc_t              desc;

  assign accept    = (state_q == ISSUE_S) && !waitrequest_i;
  assign next_addr = {1'b0, addr_q} + (AMM_ADDR_W+1)'(burst_q);
  assign next_last = next_addr + (AMM_ADDR_W+1)'(burst_q) - (AMM_ADDR_W+1)'(1);
  assign wrap      = next_last > {1'b0, end_q};
  assign words_m1  = burst_q - AMM_BURST_W'(1);

  always_comb begin
    desc.start_addr  = addr_q;
    desc.words_count = words_m1[AMM_BURST_W-2:0];
    desc.data_ptrn   = ptrn_q;
    desc.data_mode   = mode_q;
  end

  credit_cnt #(.WIDTH(DESC_W), .MAX(DESC_CREDITS)) u_desc_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (test_start_i),
    .inc_i   (accept),
    .inc_n_i (DESC_W'(1)),
    .dec_i   (cmp_desc_rd_i),
    .need_i  (DESC_W'(1)),
    .cnt_o   (desc_out),
    .ok_o    (desc_ok)
  );

  credit_cnt #(.WIDTH(WORD_W), .MAX(WORD_CREDITS)) u_word_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (test_start_i),
    .inc_i   (accept),
    .inc_n_i (WORD_W'(burst_q)),
    .dec_i   (cmp_word_rd_i),
    .need_i  (WORD_W'(burst_q)),
    .cnt_o   (word_out),
    .ok_o    (word_ok)
  );

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    adv_d        = adv_q;
    remaining_d  = remaining_q;
    trans_done_d = trans_done_q;
    ptrn_d       = ptrn_q;
    mode_d       = mode_q;
    stop_pend_d  = stop_pend_q;
    read_o       = 1'b0;
    cmp_en_o     = 1'b0;

    case (state_q)
      IDLE_S: ;
      LOAD_S: begin
        addr_d  = start_q;
        state_d = (remaining_q == '0) ? DRAIN_S : CREDIT_S;
      end
      CREDIT_S: if (desc_ok && word_ok) state_d = ISSUE_S;
      ISSUE_S: begin
        // A pending request is never withdrawn; an error only takes effect
        // once the slave has accepted it.
        read_o = 1'b1;
        if (cmp_error_i) stop_pend_d = 1'b1;
        if (accept) begin
          cmp_en_o    = 1'b1;
          remaining_d = remaining_q - 32'd1;
          if (trans_done_q != '1) trans_done_d = trans_done_q + 32'd1;
          adv_d       = '0;
          stop_pend_d = 1'b0;
          if (cmp_error_i || stop_pend_q) state_d = STOP_S;
          else if (mode_q == RND_DATA)    state_d = ADV_S;
          else                            state_d = NEXT_S;
        end
      end
      ADV_S: begin
        ptrn_d = lfsr8_step(ptrn_q);
        adv_d  = adv_q + AMM_BURST_W'(1);
        if (adv_q == words_m1) state_d = NEXT_S;
      end
      NEXT_S: begin
        addr_d  = wrap ? start_q : next_addr[AMM_ADDR_W-1:0];
        state_d = (remaining_q == '0) ? DRAIN_S : CREDIT_S;
      end
      DRAIN_S: if ((desc_out == '0) && (word_out == '0)) state_d = IDLE_S;
      STOP_S: ;
      default: state_d = IDLE_S;
    endcase

    if (cmp_error_i && (state_q != IDLE_S) && (state_q != ISSUE_S)) begin
      state_d = STOP_S;
    end

    if (test_start_i) begin
      start_d      = start_addr_i;
      end_d        = end_addr_i;
      burst_d      = burst_words_i;
      remaining_d  = trans_num_i;
      ptrn_d       = data_ptrn_i;
      mode_d       = data_mode_t'(data_mode_i);
      trans_done_d = '0;
      stop_pend_d  = 1'b0;
      state_d      = LOAD_S;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE_S;
      start_q      <= '0;
      end_q        <= '0;
      addr_q       <= '0;
      burst_q      <= '0;
      adv_q        <= '0;
      remaining_q  <= '0;
      trans_done_q <= '0;
      ptrn_q       <= '0;
      mode_q       <= FIX_DATA;
      stop_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      end_q        <= end_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      adv_q        <= adv_d;
      remaining_q  <= remaining_d;
      trans_done_q <= trans_done_d;
      ptrn_q       <= ptrn_d;
      mode_q       <= mode_d;
      stop_pend_q  <= stop_pend_d;
      busy_q       <= (state_q != IDLE_S) && (state_q != STOP_S);
    end
  end

  assign address_o    = addr_q;
  assign burstcount_o = burst_q;
  assign cmp_desc_o   = cmp_en_o ? desc : '0;
  assign busy_o       = busy_q;
  assign trans_done_o = trans_done_q;

endmodule

// File: tb/tb_amm_read_issuer.sv
// Directed bench for amm_read_issuer: expected descriptors are queued per run
// and a monitor pops and compares them on every cmp_en_o pulse.
module tb_amm_read_issuer;
  import amm_read_issuer_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic                         test_start_i;
  logic [AMM_ADDR_W-1:0]        start_addr_i, end_addr_i;
  logic [AMM_BURST_W-1:0]       burst_words_i;
  logic [31:0]                  trans_num_i;
  logic [7:0]                   data_ptrn_i;
  logic                         data_mode_i;
  logic [AMM_ADDR_W-1:0]        address_o;
  logic                         read_o;
  logic [AMM_BURST_W-1:0]       burstcount_o;
  logic                         waitrequest_i;
  logic                         cmp_en_o;
  logic [$bits(cmp_desc_t)-1:0] cmp_desc_o;
  logic                         cmp_desc_rd_i, cmp_word_rd_i, cmp_error_i;
  logic                         busy_o;
  logic [31:0]                  trans_done_o;

  amm_read_issuer #(.DESC_CREDITS(4), .WORD_CREDITS(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_start_i(test_start_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .burst_words_i(burst_words_i), .trans_num_i(trans_num_i),
    .data_ptrn_i(data_ptrn_i), .data_mode_i(data_mode_i),
    .address_o(address_o), .read_o(read_o), .burstcount_o(burstcount_o),
    .waitrequest_i(waitrequest_i), .cmp_en_o(cmp_en_o), .cmp_desc_o(cmp_desc_o),
    .cmp_desc_rd_i(cmp_desc_rd_i), .cmp_word_rd_i(cmp_word_rd_i),
    .cmp_error_i(cmp_error_i), .busy_o(busy_o), .trans_done_o(trans_done_o)
  );

  typedef struct {
    logic [AMM_ADDR_W-1:0]  addr;
    logic [AMM_BURST_W-2:0] wc;
    logic [7:0]             p;
    logic                   m;
  } exp_t;

  exp_t exp_q[$];
  int   en_cyc_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, en_count = 0, rd_rise = 0;
  int   desc_pend = 0, word_pend = 0, word_budget = 0, last_word_cyc = 0;
  bit   desc_pop_en = 1'b0;

  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input int a, input int wc, input int p, input bit m);
    exp_t e;
    e.addr = AMM_ADDR_W'(a);
    e.wc   = (AMM_BURST_W-1)'(wc);
    e.p    = 8'(p);
    e.m    = m;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input int s, input int e, input int b, input int n,
                           input int p, input bit m);
    tick();
    start_addr_i  = AMM_ADDR_W'(s);
    end_addr_i    = AMM_ADDR_W'(e);
    burst_words_i = AMM_BURST_W'(b);
    trans_num_i   = 32'(n);
    data_ptrn_i   = 8'(p);
    data_mode_i   = m;
    test_start_i  = 1'b1;
    tick();
    test_start_i  = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    while (!busy_o && n < maxc) begin @(negedge clk_i); n++; end
    while (busy_o && n < maxc) begin @(negedge clk_i); n++; end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy_o still %0b after %0d cycles, required 0", name, busy_o, maxc);
    end
  endtask

  task automatic wait_read(input int maxc, input string name);
    int n = 0;
    while (!read_o && n < maxc) begin @(negedge clk_i); n++; end
    check({name, "_read_seen"}, read_o, 1);
  endtask

  task automatic wait_en(input int cnt, input int maxc, input string name);
    int n = 0;
    while (en_count < cnt && n < maxc) begin @(negedge clk_i); n++; end
    check({name, "_push_seen"}, en_count, cnt);
  endtask

  function automatic int en_gap(input int a, input int b);
    if (en_cyc_q.size() > b) return en_cyc_q[b] - en_cyc_q[a];
    return -1;
  endfunction

  // Scoreboard monitor: descriptor contents, read address at acceptance,
  // and stability of a stalled request.
  initial begin
    logic                  prev_rd = 1'b0, prev_acc = 1'b0;
    logic [AMM_ADDR_W+AMM_BURST_W-1:0] prev_ab = '0;
    cmp_desc_t d;
    exp_t      e;
    forever begin
      @(negedge clk_i);
      if (read_o && !prev_rd) rd_rise++;
      if (read_o && prev_rd && !prev_acc)
        check("req_hold", {address_o, burstcount_o}, prev_ab);
      if (cmp_en_o) begin
        en_count++;
        en_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push: desc %0h with empty queue, required no push", cmp_desc_o);
        end else begin
          e = exp_q.pop_front();
          d = cmp_desc_t'(cmp_desc_o);
          check("desc_addr", d.start_addr, e.addr);
          check("desc_words", d.words_count, e.wc);
          check("desc_ptrn", d.data_ptrn, e.p);
          check("desc_mode", d.data_mode, e.m);
          check("rd_addr", address_o, e.addr);
        end
      end
      prev_rd  = read_o;
      prev_acc = cmp_en_o;
      prev_ab  = {address_o, burstcount_o};
    end
  end

  // Compare-stage consumer; a pop is only issued the cycle after the push.
  initial begin
    cmp_desc_rd_i = 1'b0;
    cmp_word_rd_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      cmp_desc_rd_i = desc_pop_en && (desc_pend > 0);
      if (cmp_desc_rd_i) desc_pend--;
      cmp_word_rd_i = (word_budget > 0) && (word_pend > 0);
      if (cmp_word_rd_i) begin
        word_pend--;
        word_budget--;
        last_word_cyc = cyc;
      end
      @(negedge clk_i);
      if (cmp_en_o) begin
        desc_pend++;
        word_pend += int'(burstcount_o);
      end
    end
  end

  initial begin
    int rr, busy_cnt;
    rst_i = 1'b1; test_start_i = 1'b0; waitrequest_i = 1'b0; cmp_error_i = 1'b0;
    start_addr_i = '0; end_addr_i = '0; burst_words_i = '0; trans_num_i = '0;
    data_ptrn_i = '0; data_mode_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_read", read_o, 0);
    check("rst_cmp_en", cmp_en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_trans_done", trans_done_o, 0);
    check("rst_address", address_o, 0);
    check("rst_burstcount", burstcount_o, 0);
    check("rst_desc", cmp_desc_o, 0);
    tick();
    rst_i = 1'b0;

    // Linear fixed-pattern run
    desc_pop_en = 1'b1; word_budget = 1000000;
    en_count = 0; en_cyc_q.delete();
    push_exp('h100, 3, 'hA5, 0); push_exp('h104, 3, 'hA5, 0); push_exp('h108, 3, 'hA5, 0);
    start_run('h100, 'h1FF, 4, 3, 'hA5, 0);
    wait_idle(200, "lin");
    check("lin_trans_done", trans_done_o, 3);
    check("lin_pushes", en_count, 3);
    check("lin_queue_empty", exp_q.size(), 0);
    check("lin_gap", en_gap(0, 1), 3);

    // Window wrap
    en_count = 0;
    push_exp('h0, 3, 'h33, 0); push_exp('h4, 3, 'h33, 0); push_exp('h8, 3, 'h33, 0);
    push_exp('h0, 3, 'h33, 0); push_exp('h4, 3, 'h33, 0);
    start_run('h0, 'hB, 4, 5, 'h33, 0);
    wait_idle(300, "wrap");
    check("wrap_pushes", en_count, 5);
    check("wrap_trans_done", trans_done_o, 5);

    // Random pattern: 0x01 -> 0x03 -> 0x06 after two steps
    en_count = 0; en_cyc_q.delete();
    push_exp('h20, 1, 'h01, 1); push_exp('h22, 1, 'h06, 1);
    start_run('h20, 'hFF, 2, 2, 'h01, 1);
    wait_idle(200, "rnd");
    check("rnd_pushes", en_count, 2);
    check("rnd_gap", en_gap(0, 1), 5);

    // Word-credit stall with 32-word bursts
    en_count = 0; en_cyc_q.delete(); word_budget = 0;
    push_exp('h0, 31, 'h11, 0); push_exp('h20, 31, 'h11, 0); push_exp('h40, 31, 'h11, 0);
    start_run('h0, 'hFFF, 32, 3, 'h11, 0);
    wait_en(2, 100, "stall");
    rr = rd_rise;
    repeat (30) @(negedge clk_i);
    check("stall_pushes", en_count, 2);
    check("stall_no_read", rd_rise - rr, 0);
    check("stall_read_low", read_o, 0);
    word_budget = 32;
    wait_en(3, 100, "stall_resume");
    check("stall_resume_lat", (en_cyc_q.size() > 2) ? en_cyc_q[2] - last_word_cyc : -1, 2);
    word_budget = 1000000;
    wait_idle(300, "stall");

    // Descriptor-credit stall with 1-word bursts
    en_count = 0; desc_pop_en = 1'b0;
    for (int i = 0; i < 6; i++) push_exp('h50 + i, 0, 'h22, 0);
    start_run('h50, 'hFFF, 1, 6, 'h22, 0);
    repeat (40) @(negedge clk_i);
    check("dstall_pushes", en_count, 4);
    desc_pop_en = 1'b1;
    wait_idle(200, "dstall");
    check("dstall_total", en_count, 6);
    check("dstall_trans_done", trans_done_o, 6);

    // Waitrequest stall with error rising mid-request
    en_count = 0; rd_rise = 0;
    tick();
    waitrequest_i = 1'b1;
    push_exp('h200, 3, 'h5A, 0);
    start_run('h200, 'h2FF, 4, 4, 'h5A, 0);
    wait_read(20, "err");
    tick();
    cmp_error_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("err_read_held", read_o, 1);
    check("err_addr_held", address_o, 'h200);
    check("err_no_push_yet", en_count, 0);
    tick();
    waitrequest_i = 1'b0;
    wait_en(1, 10, "err");
    repeat (10) @(negedge clk_i);
    check("err_pushes", en_count, 1);
    check("err_read_reqs", rd_rise, 1);
    check("err_read_low", read_o, 0);
    check("err_busy", busy_o, 0);
    check("err_trans_done", trans_done_o, 1);
    tick();
    cmp_error_i = 1'b0;
    push_exp('h300, 3, 'h77, 0);
    start_run('h300, 'h3FF, 4, 1, 'h77, 0);
    wait_idle(100, "restart");
    check("restart_pushes", en_count, 2);
    check("restart_trans_done", trans_done_o, 1);

    // Asynchronous reset while a request is stalled
    en_count = 0;
    push_exp('h400, 3, 'h99, 0);
    start_run('h400, 'h4FF, 4, 3, 'h99, 0);
    wait_en(1, 20, "arst");
    tick();
    waitrequest_i = 1'b1;
    wait_read(10, "arst");
    check("arst_pre_done", trans_done_o, 1);
    #2;
    rst_i = 1'b1;
    desc_pend = 0; word_pend = 0;
    #1;
    check("arst_read", read_o, 0);
    check("arst_cmp_en", cmp_en_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_trans_done", trans_done_o, 0);
    check("arst_address", address_o, 0);
    check("arst_burstcount", burstcount_o, 0);
    check("arst_desc", cmp_desc_o, 0);
    check("arst_queue_empty", exp_q.size(), 0);
    tick();
    rst_i = 1'b0;
    waitrequest_i = 1'b0;

    // Zero-transaction run: busy only through LOAD_S and DRAIN_S
    en_count = 0; rd_rise = 0; busy_cnt = 0;
    start_run('h10, 'hFF, 4, 0, 'h00, 0);
    repeat (10) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
    end
    check("zero_busy_cycles", busy_cnt, 2);
    check("zero_reads", rd_rise, 0);
    check("zero_pushes", en_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
